core_sequencer: RTL

Parametrised control sequencer for the BeeF core. It replaces the fixed single-level branch state handling with three owned resources: a PC register, a loop-return stack of configurable depth, and a forward-skip nesting counter. Together these execute CBF/CBB (`[`/`]`) with arbitrary nesting and sticky fault reporting. It sits between instruction fetch and the core_control decoder, and gates the decoder's datapath writes through `exec_en`.

---
 rtl/core_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// BeeF control sequencer: PC, loop-return stack and forward-skip nesting counter.
// Executes CBF/CBB with arbitrary nesting and latches the first fault until reset.

package core_sequencer_pkg;
  typedef enum logic [3:0] {
    INC = 4'd0,
    DEC = 4'd1,
    PSH = 4'd2,
    POP = 4'd3,
    MVR = 4'd4,
    MVL = 4'd5,
    CBF = 4'd6,
    CBB = 4'd7,
    NOP = 4'd8
  } op_code;
endpackage

module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned      PC_W        = 16,
  parameter int unsigned      CACHE_DEPTH = 8,
  parameter int unsigned      SKIP_W      = 8,
  parameter logic [PC_W-1:0]  RESET_PC    = '0,
  localparam int unsigned     LVL_W       = $clog2(CACHE_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  op_code           instruction,
  input  logic             acc_zero,
  output logic [PC_W-1:0]  pc,
  output logic [1:0]       state,
  output logic             exec_en,
  output logic [LVL_W-1:0] stack_level,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int unsigned IDX_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;

  localparam logic [1:0] CORE_S       = 2'd0;
  localparam logic [1:0] BRANCH_S     = 2'd1;
  localparam logic [1:0] CACHE_SAVE_S = 2'd2;
  localparam logic [1:0] FAULT_S      = 2'd3;

  localparam logic [1:0] FC_NONE      = 2'd0;
  localparam logic [1:0] FC_OVERFLOW  = 2'd1;
  localparam logic [1:0] FC_UNDERFLOW = 2'd2;
  localparam logic [1:0] FC_DEPTH     = 2'd3;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [1:0]        state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              fault_q, fault_d;
  logic [1:0]        code_q, code_d;
  logic [PC_W-1:0]   stack_q [CACHE_DEPTH];
  logic [PC_W-1:0]   stack_d [CACHE_DEPTH];

  logic [IDX_W-1:0]  push_idx, top_idx;
  logic              is_branch_op;

  assign push_idx     = IDX_W'(level_q);
  assign top_idx      = IDX_W'(level_q - 1'b1);
  assign is_branch_op = (instruction == CBF) || (instruction == CBB);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    level_d = level_q;
    skip_d  = skip_q;
    fault_d = fault_q;
    code_d  = code_q;
    stack_d = stack_q;
    case (state_q)
      CORE_S: begin
        if (instr_valid) begin
          case (instruction)
            CBF: begin
              if (acc_zero) begin
                skip_d  = SKIP_W'(1);
                pc_d    = pc_q + 1'b1;
                state_d = BRANCH_S;
              end else if (level_q < LVL_W'(CACHE_DEPTH)) begin
                // pc holds so the CBF address itself is the loop return point
                stack_d[push_idx] = pc_q;
                level_d           = level_q + 1'b1;
                state_d           = CACHE_SAVE_S;
              end else begin
                state_d = FAULT_S;
                fault_d = 1'b1;
                code_d  = FC_OVERFLOW;
              end
            end
            CBB: begin
              if (level_q == '0) begin
                state_d = FAULT_S;
                fault_d = 1'b1;
                code_d  = FC_UNDERFLOW;
              end else if (!acc_zero) begin
                pc_d = stack_q[top_idx] + 1'b1;
              end else begin
                level_d = level_q - 1'b1;
                pc_d    = pc_q + 1'b1;
              end
            end
            default: pc_d = pc_q + 1'b1;
          endcase
        end
      end
      CACHE_SAVE_S: begin
        pc_d    = pc_q + 1'b1;
        state_d = CORE_S;
      end
      BRANCH_S: begin
        if (instr_valid) begin
          case (instruction)
            CBF: begin
              if (&skip_q) begin
                state_d = FAULT_S;
                fault_d = 1'b1;
                code_d  = FC_DEPTH;
              end else begin
                skip_d = skip_q + 1'b1;
                pc_d   = pc_q + 1'b1;
              end
            end
            CBB: begin
              skip_d = skip_q - 1'b1;
              pc_d   = pc_q + 1'b1;
              if (skip_q == SKIP_W'(1)) state_d = CORE_S;
            end
            default: pc_d = pc_q + 1'b1;
          endcase
        end
      end
      default: ;  // FAULT_S: everything frozen until reset
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      state_q <= CORE_S;
      level_q <= '0;
      skip_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      level_q <= level_d;
      skip_q  <= skip_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      stack_q <= stack_d;
    end
  end

  assign exec_en     = (state_q == CORE_S) && instr_valid && !is_branch_op;
  assign pc          = pc_q;
  assign state       = state_q;
  assign stack_level = level_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule
